// File: rtl/led_blink_ctrl.sv
// Command-driven LED sequencer: clear, solid, blink N times or blink forever, with
// per-phase timing from a down-counter and a one-cycle done pulse on natural completion.
module led_blink_ctrl #(
    parameter int unsigned CNT_W   = 28,
    parameter int unsigned N_LED   = 2,
    parameter int unsigned CNT_N_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [N_LED-1:0]   cmd_mask,
    input  logic [CNT_W-1:0]   cmd_half,
    input  logic [CNT_N_W-1:0] cmd_count,
    input  logic               abort,
    output logic [N_LED-1:0]   LED,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {StIdle, StOn, StOff} state_e;

    localparam logic [1:0] OpClear   = 2'b00;
    localparam logic [1:0] OpSolid   = 2'b01;
    localparam logic [1:0] OpBlinkN  = 2'b10;
    localparam logic [1:0] OpForever = 2'b11;

    state_e             r_state,     w_state_d;
    logic [CNT_W-1:0]   r_timer,     w_timer_d;
    logic [CNT_W-1:0]   r_reload,    w_reload_d;
    logic [CNT_N_W-1:0] r_remaining, w_remaining_d;
    logic [N_LED-1:0]   r_mask,      w_mask_d;
    logic [N_LED-1:0]   r_led,       w_led_d;
    logic               r_forever,   w_forever_d;
    logic               r_done,      w_done_d;

    // Reload value is h-1 with h = max(cmd_half, 1), so the largest half never overflows.
    logic [CNT_W-1:0]   w_cmd_reload;
    assign w_cmd_reload = (cmd_half == '0) ? '0 : cmd_half - CNT_W'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_timer     <= '0;
            r_reload    <= '0;
            r_remaining <= '0;
            r_mask      <= '0;
            r_led       <= '0;
            r_forever   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_timer     <= w_timer_d;
            r_reload    <= w_reload_d;
            r_remaining <= w_remaining_d;
            r_mask      <= w_mask_d;
            r_led       <= w_led_d;
            r_forever   <= w_forever_d;
            r_done      <= w_done_d;
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_timer_d     = r_timer;
        w_reload_d    = r_reload;
        w_remaining_d = r_remaining;
        w_mask_d      = r_mask;
        w_led_d       = r_led;
        w_forever_d   = r_forever;
        w_done_d      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (cmd_valid) begin
                    unique case (cmd_op)
                        OpClear: begin
                            w_led_d  = '0;
                            w_done_d = 1'b1;
                        end
                        OpSolid: begin
                            w_led_d  = cmd_mask;
                            w_done_d = 1'b1;
                        end
                        OpBlinkN, OpForever: begin
                            if (cmd_op == OpBlinkN && cmd_count == '0) begin
                                w_led_d  = '0;
                                w_done_d = 1'b1;
                            end else begin
                                w_led_d       = cmd_mask;
                                w_mask_d      = cmd_mask;
                                w_state_d     = StOn;
                                w_timer_d     = w_cmd_reload;
                                w_reload_d    = w_cmd_reload;
                                w_remaining_d = cmd_count;
                                w_forever_d   = (cmd_op == OpForever);
                            end
                        end
                        default: ;
                    endcase
                end
            end
            StOn: begin
                if (abort) begin
                    w_led_d   = '0;
                    w_state_d = StIdle;
                    w_timer_d = '0;
                end else if (r_timer != '0) begin
                    w_timer_d = r_timer - CNT_W'(1);
                end else begin
                    w_led_d   = '0;
                    w_state_d = StOff;
                    w_timer_d = r_reload;
                end
            end
            StOff: begin
                if (abort) begin
                    w_led_d   = '0;
                    w_state_d = StIdle;
                    w_timer_d = '0;
                end else if (r_timer != '0) begin
                    w_timer_d = r_timer - CNT_W'(1);
                end else if (!r_forever && r_remaining == CNT_N_W'(1)) begin
                    w_state_d = StIdle;
                    w_done_d  = 1'b1;
                end else begin
                    if (!r_forever) begin
                        w_remaining_d = r_remaining - CNT_N_W'(1);
                    end
                    w_led_d   = r_mask;
                    w_state_d = StOn;
                    w_timer_d = r_reload;
                end
            end
            default: begin
                w_led_d   = '0;
                w_state_d = StIdle;
                w_timer_d = '0;
            end
        endcase
    end

    always_comb begin
        cmd_ready = (r_state == StIdle);
        busy      = (r_state != StIdle);
        LED       = r_led;
        done      = r_done;
    end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Directed bench for led_blink_ctrl: status {LED, busy, cmd_ready, done} is sampled 1 ns
// after each rising edge and compared against hand-computed values.
module tb_led_blink_ctrl;

    localparam int unsigned CNT_W   = 28;
    localparam int unsigned N_LED   = 2;
    localparam int unsigned CNT_N_W = 8;

    localparam logic [1:0] OpClear   = 2'b00;
    localparam logic [1:0] OpSolid   = 2'b01;
    localparam logic [1:0] OpBlinkN  = 2'b10;
    localparam logic [1:0] OpForever = 2'b11;

    logic               clock;
    logic               reset;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [N_LED-1:0]   cmd_mask;
    logic [CNT_W-1:0]   cmd_half;
    logic [CNT_N_W-1:0] cmd_count;
    logic               abort;
    logic [N_LED-1:0]   LED;
    logic               busy;
    logic               done;

    int n_tests;
    int n_fail;

    led_blink_ctrl #(
        .CNT_W   (CNT_W),
        .N_LED   (N_LED),
        .CNT_N_W (CNT_N_W)
    ) u_dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_mask  (cmd_mask),
        .cmd_half  (cmd_half),
        .cmd_count (cmd_count),
        .abort     (abort),
        .LED       (LED),
        .busy      (busy),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] status();
        return {27'b0, LED, busy, cmd_ready, done};
    endfunction

    // Expected status word from its fields.
    function automatic logic [31:0] st(input logic [1:0] led, input logic b, input logic r,
                                       input logic d);
        return {27'b0, led, b, r, d};
    endfunction

    // Presents a command for one cycle; returns 1 ns after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [1:0] mask,
                         input logic [CNT_W-1:0] half, input logic [CNT_N_W-1:0] count);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_mask  = mask;
        cmd_half  = half;
        cmd_count = count;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OpClear;
        cmd_mask  = '0;
        cmd_half  = '0;
        cmd_count = '0;
        abort     = 1'b0;

        tick();
        check_eq("reset_state", status(), st(2'b00, 1'b0, 1'b1, 1'b0));
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("idle", status(), st(2'b00, 1'b0, 1'b1, 1'b0));
        end

        // SOLID then CLEAR
        issue(OpSolid, 2'b10, 28'd0, 8'd0);
        check_eq("solid_accept", status(), st(2'b10, 1'b0, 1'b1, 1'b1));
        tick();
        check_eq("solid_after", status(), st(2'b10, 1'b0, 1'b1, 1'b0));
        issue(OpClear, 2'b11, 28'd0, 8'd0);
        check_eq("clear_accept", status(), st(2'b00, 1'b0, 1'b1, 1'b1));
        tick();
        check_eq("clear_after", status(), st(2'b00, 1'b0, 1'b1, 1'b0));

        // BLINK_N mask=11 half=3 count=2: 3 on, 3 off, 3 on, 3 off, done at accept+12
        issue(OpBlinkN, 2'b11, 28'd3, 8'd2);
        for (int i = 0; i < 12; i++) begin
            check_eq("blink_n2", status(),
                     st((((i / 3) % 2) == 0) ? 2'b11 : 2'b00, 1'b1, 1'b0, 1'b0));
            tick();
        end
        check_eq("blink_n2_done", status(), st(2'b00, 1'b0, 1'b1, 1'b1));
        tick();
        check_eq("blink_n2_post", status(), st(2'b00, 1'b0, 1'b1, 1'b0));

        // half=0 behaves as half=1
        issue(OpBlinkN, 2'b01, 28'd0, 8'd1);
        check_eq("half0_on", status(), st(2'b01, 1'b1, 1'b0, 1'b0));
        tick();
        check_eq("half0_off", status(), st(2'b00, 1'b1, 1'b0, 1'b0));
        tick();
        check_eq("half0_done", status(), st(2'b00, 1'b0, 1'b1, 1'b1));
        tick();
        check_eq("half0_post", status(), st(2'b00, 1'b0, 1'b1, 1'b0));

        // count=0 acts as CLEAR; light LEDs first so the drop is visible
        issue(OpSolid, 2'b11, 28'd0, 8'd0);
        check_eq("solid11", status(), st(2'b11, 1'b0, 1'b1, 1'b1));
        tick();
        issue(OpBlinkN, 2'b11, 28'd4, 8'd0);
        check_eq("count0_done", status(), st(2'b00, 1'b0, 1'b1, 1'b1));
        tick();
        check_eq("count0_post", status(), st(2'b00, 1'b0, 1'b1, 1'b0));

        // abort in IDLE alongside a command: command wins
        abort = 1'b1;
        issue(OpSolid, 2'b01, 28'd0, 8'd0);
        abort = 1'b0;
        check_eq("idle_abort_cmd", status(), st(2'b01, 1'b0, 1'b1, 1'b1));
        tick();

        // BLINK_FOREVER mask=01 half=5: period 10, never done
        issue(OpForever, 2'b01, 28'd5, 8'd1);
        for (int i = 0; i < 100; i++) begin
            check_eq("forever", status(),
                     st((((i / 5) % 2) == 0) ? 2'b01 : 2'b00, 1'b1, 1'b0, 1'b0));
            tick();
        end
        // Now at the first cycle of an ON phase; abort with a new command held.
        abort     = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = OpSolid;
        cmd_mask  = 2'b10;
        check_eq("forever_on_pre_abort", status(), st(2'b01, 1'b1, 1'b0, 1'b0));
        tick();
        abort = 1'b0;
        check_eq("abort_idle", status(), st(2'b00, 1'b0, 1'b1, 1'b0));
        tick();
        cmd_valid = 1'b0;
        check_eq("held_cmd_accept", status(), st(2'b10, 1'b0, 1'b1, 1'b1));
        tick();
        check_eq("held_cmd_post", status(), st(2'b10, 1'b0, 1'b1, 1'b0));

        // Async reset mid-ON
        issue(OpBlinkN, 2'b11, 28'd10, 8'd3);
        tick();
        tick();
        check_eq("pre_reset_on", status(), st(2'b11, 1'b1, 1'b0, 1'b0));
        #3;
        reset = 1'b1;
        #1;
        check_eq("async_reset", status(), st(2'b00, 1'b0, 1'b1, 1'b0));
        #2;
        reset = 1'b0;
        for (int i = 0; i < 70; i++) begin
            tick();
            check_eq("post_reset_quiet", status(), st(2'b00, 1'b0, 1'b1, 1'b0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
